audio_dac_interp: RTL and testbench
===================================

Name: audio_dac_interp

Overview:
- Upstream feeder for the 1-bit delta-sigma DAC.
- Accepts PCM samples at the audio rate through a valid/ready stream and buffers them in a small FIFO.
- Generates the DAC's clk_en strobe and drives the DAC's signed q0.15 input.
- The output is linearly interpolated between consecutive samples at the clk_en rate, which lowers the zero-order-hold images the modulator would otherwise shape.

Parameters:
- W, 16, sample width (signed q0.(W-1)); matches the DAC input width.
- FIFO_DEPTH, 8, sample FIFO entries; power of 2, >=4.
- OSR_LOG2, 8, log2 of the clk_en ticks per input sample (256 → 48.8 kHz at 12.5 MHz).
- CLK_DIV, 4, clk cycles per clk_en pulse (50 MHz → 12.5 MHz); >=1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low flushes the block and returns it to IDLE
- s_data  in  W  signed input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept
- clk_en  out  1  one-clk pulse every CLK_DIV clks; drives the DAC clk_en
- dac_in  out  W  signed interpolated sample to the DAC `in`
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- underflow  out  1  one-clk pulse when the FIFO is empty at a sample boundary in RUN

Behaviour:
- Reset (async, rst=1): div counter=0, phase=0, prev=cur=0, FIFO empty, state=IDLE. Outputs: dac_in=0, clk_en=0, underflow=0, s_ready=0 while rst is high, level=0.
- Divider:
  - The counter runs 0..CLK_DIV-1 continuously, independent of en.
  - clk_en=1 in the clk cycle where the counter==CLK_DIV-1.
  - CLK_DIV=1 gives clk_en constantly 1.
- FIFO:
  - Push when s_valid&&s_ready.
  - s_ready = !full && en, where full is evaluated before any same-cycle pop (no push-through when full).
  - Pop and push in the same cycle are allowed when not full; level is unchanged in that case.
  - en=0: the FIFO is flushed synchronously (level=0) and s_ready=0.
- IDLE state:
  - dac_in, prev, cur and phase are held at 0.
  - On a clk_en cycle with en=1 and level >= FIFO_DEPTH/2: pop head into cur, prev<=0, phase<=0, go to RUN.
- RUN state, on each clk_en:
  - dac_in <= prev + (((cur-prev) * phase) >>> OSR_LOG2), evaluated with the pre-update prev/cur/phase.
  - Arithmetic width: diff is W+1 signed; product is W+1+OSR_LOG2 signed; the shift is arithmetic (floor).
  - The result is always within [min(prev,cur), max(prev,cur)] and is truncated to W bits with no saturation logic.
  - phase <= phase+1, wrapping modulo 2^OSR_LOG2.
  - If phase == 2^OSR_LOG2-1 (sample boundary):
    - FIFO non-empty: prev<=cur, cur<=head, pop.
    - FIFO empty: prev<=cur, cur unchanged (the output settles flat at the last sample); underflow=1 for exactly that clk cycle.
- RUN → IDLE only when en=0. The transition is immediate (next clk, not gated by clk_en): dac_in<=0, prev/cur/phase<=0, FIFO flushed.
- Between clk_en pulses, dac_in and all datapath registers hold.
- Latency:
  - The sample popped at boundary tick T first reaches dac_in as the pure value prev'=that sample at tick T+2^OSR_LOG2+1.
  - In general, dac_in at tick k reflects the state registered at tick k-1.
- Reset mid-operation: all state returns to reset values asynchronously, regardless of clk_en phase or FIFO contents.

Test Plan:
- Reset/cadence (CLK_DIV=4): release rst → clk_en pulses exactly every 4th clk (cycles 3, 7, 11, …); dac_in=0; level=0; s_ready=1 once en=1.
- Ramp (CLK_DIV=1, OSR_LOG2=2, FIFO_DEPTH=4): push 0, 400, 800, 1200, holding en=1.
  - RUN is entered once level>=2.
  - dac_in sequence: 0,0,0,0, then 0,100,200,300, then 400,500,600,700; no gaps while the FIFO is fed.
- Extreme swing (OSR_LOG2=2): prev=32767, cur=-32768 → dac_in = 32767, 16383, -1, -16385, monotonic with no wrap.
- Underflow: stop pushing while in RUN → at the first empty boundary, underflow pulses exactly 1 clk and dac_in settles at the last sample. Resuming pushes restarts interpolation from that value.
- Backpressure: fill FIFO_DEPTH=8 while in IDLE below threshold, then hold s_valid=1 → s_ready=0 at level=8; no sample is lost or duplicated across the first pop; level reads back 8→7.
- Mid-run abort: deassert en or pulse rst during phase=2 → next clk dac_in=0, level=0, state IDLE; re-enable and refill → ramp sequence repeats identically.

Source files
------------

// File: rtl/audio_dac_interp.sv
// audio_dac_interp: buffers PCM samples, strobes the DAC clk_en and feeds it linearly interpolated samples
module audio_dac_interp #(
  parameter int W          = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int OSR_LOG2   = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [W-1:0]                  s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          clk_en,
  output logic [W-1:0]                  dac_in,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = W + OSR_LOG2 + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] div_q;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [W-1:0] prev_q, prev_d, cur_q, cur_d, dac_q, dac_d, head;
  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic push, pop, empty, full;
  logic signed [W:0] diff;
  logic signed [PW-1:0] step;
  assign clk_en = !rst && div_q == CW'(CLK_DIV - 1);
  assign level = wr_q - rd_q;
  assign empty = level == '0;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign s_ready = !rst && en && !full;
  assign push = s_valid && s_ready;
  assign head = mem_q[rd_q[AW-1:0]];
  assign dac_in = dac_q;
  // diff and product are wide enough that the floor shift never overflows
  assign diff = $signed({cur_q[W-1], cur_q}) - $signed({prev_q[W-1], prev_q});
  assign step = (PW'(diff) * PW'($signed({1'b0, phase_q}))) >>> OSR_LOG2;
  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else div_q <= clk_en ? '0 : div_q + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (!en) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push);
      rd_q <= rd_q + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= s_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      phase_q <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      phase_q <= phase_d;
      dac_q   <= dac_d;
    end
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    phase_d   = phase_q;
    dac_d     = dac_q;
    pop       = 1'b0;
    underflow = 1'b0;
    if (!en) begin
      state_d = IDLE;
      prev_d  = '0;
      cur_d   = '0;
      phase_d = '0;
      dac_d   = '0;
    end else if (state_q == IDLE) begin
      if (clk_en && level >= (AW+1)'(FIFO_DEPTH / 2)) begin
        state_d = RUN;
        pop     = 1'b1;
        cur_d   = head;
        prev_d  = '0;
        phase_d = '0;
      end
    end else if (clk_en) begin
      dac_d   = prev_q + step[W-1:0];
      phase_d = phase_q + OSR_LOG2'(1);
      // an empty FIFO at the boundary repeats cur so the output goes flat
      if (&phase_q) begin
        prev_d    = cur_q;
        pop       = !empty;
        underflow = empty;
        cur_d     = empty ? cur_q : head;
      end
    end
  end
endmodule

// File: tb/tb_audio_dac_interp.sv
// tb_audio_dac_interp: scenario tasks checked against a sample-list interpolation model
module tb_audio_dac_interp;
  localparam int W = 16, D = 8, OSR = 2, R = 4, CD = 4;
  logic clk = 0, rst = 1, en = 0, s_valid = 0;
  logic signed [W-1:0] s_data = '0;
  logic s_ready, clk_en, underflow;
  logic signed [W-1:0] dac_in;
  logic [3:0] level;
  logic rdy1, ce1, uf1;
  logic [W-1:0] dac1;
  logic [3:0] lvl1;
  int total = 0, bad = 0;
  int mdiv, m_n, m_dac;
  int mq[$];
  int played[$];
  bit m_run;
  bit e_ce, e_rdy, e_uf;
  int e_lvl;

  audio_dac_interp #(.W(W), .FIFO_DEPTH(D), .OSR_LOG2(OSR), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .clk_en(clk_en), .dac_in(dac_in), .level(level), .underflow(underflow));
  audio_dac_interp #(.W(W), .FIFO_DEPTH(D), .OSR_LOG2(OSR), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(1'b0), .s_data('0), .s_valid(1'b0), .s_ready(rdy1),
    .clk_en(ce1), .dac_in(dac1), .level(lvl1), .underflow(uf1));

  always #5 clk = ~clk;

  function automatic int fdiv(int a, int b);
    return a >= 0 ? a / b : -((-a + b - 1) / b);
  endfunction

  task automatic m_flush();
    mq.delete();
    played.delete();
    m_run = 0;
    m_n = 0;
    m_dac = 0;
  endtask

  task automatic model_clear();
    m_flush();
    mdiv = 0;
  endtask

  task automatic upd_exp();
    e_ce  = !rst && mdiv == CD - 1;
    e_rdy = !rst && en && mq.size() < D;
    e_lvl = mq.size();
    e_uf  = !rst && en && m_run && e_ce && (m_n % R == R - 1) && mq.size() == 0;
  endtask

  // Advance one clock: update the model at posedge, land on the next negedge.
  task automatic cyc();
    bit ce, push;
    int d, j, p, a, b;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      ce = mdiv == CD - 1;
      push = s_valid && en && mq.size() < D;
      d = s_data;
      mdiv = (mdiv + 1) % CD;
      if (!en) m_flush();
      else begin
        if (!m_run) begin
          if (ce && mq.size() >= D / 2) begin
            m_run = 1;
            m_n = 0;
            played.delete();
            played.push_back(0);
            played.push_back(mq.pop_front());
          end
        end else if (ce) begin
          j = m_n / R;
          p = m_n % R;
          a = played[j];
          b = played[j+1];
          m_dac = a + fdiv((b - a) * p, R);
          if (p == R - 1) begin
            if (mq.size() > 0) played.push_back(mq.pop_front());
            else played.push_back(b);
          end
          m_n++;
        end
        if (push) mq.push_back(d);
      end
    end
    @(negedge clk);
    upd_exp();
  endtask

  task automatic test_reset();
    rst = 1; en = 0; s_valid = 0;
    repeat (3) cyc();
    total++; if (dac_in !== 16'sd0) begin bad++; $display("FAIL rst_dac: got %0d want 0", dac_in); end
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL rst_clk_en: got %b want 0", clk_en); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uf: got %b want 0", underflow); end
    total++; if (ce1 !== 1'b0) begin bad++; $display("FAIL rst_ce_div1: got %b want 0", ce1); end
    rst = 0;
    upd_exp();
    for (int i = 0; i < 12; i++) begin
      cyc();
      total++; if (clk_en !== (i % 4 == 2)) begin bad++; $display("FAIL cadence[%0d]: got %b want %b", i, clk_en, i % 4 == 2); end
      total++; if (ce1 !== 1'b1) begin bad++; $display("FAIL ce_div1[%0d]: got %b want 1", i, ce1); end
      total++; if (dac_in !== 16'sd0) begin bad++; $display("FAIL idle_dac[%0d]: got %0d want 0", i, dac_in); end
    end
    en = 1;
    cyc();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL en_ready: got %b want 1", s_ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL en_level: got %0d want 0", level); end
  endtask

  task automatic test_ramp(input string tag);
    int vals[4] = '{0, 400, 800, 1200};
    int want[12] = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 500, 600, 700};
    int got[$];
    bit was_ce, was_run;
    en = 1;
    foreach (vals[k]) begin
      s_valid = 1;
      s_data = 16'(vals[k]);
      cyc();
      total++; if (level !== 4'(e_lvl)) begin bad++; $display("FAIL %s fill_level: got %0d want %0d", tag, level, e_lvl); end
    end
    s_valid = 0;
    for (int i = 0; i < 200 && got.size() < 12; i++) begin
      was_ce = e_ce;
      was_run = m_run;
      cyc();
      total++; if (dac_in !== 16'(m_dac)) begin bad++; $display("FAIL %s dac: got %0d want %0d", tag, dac_in, m_dac); end
      total++; if (underflow !== e_uf) begin bad++; $display("FAIL %s uf: got %b want %b", tag, underflow, e_uf); end
      total++; if (s_ready !== e_rdy) begin bad++; $display("FAIL %s ready: got %b want %b", tag, s_ready, e_rdy); end
      if (was_ce && was_run) got.push_back(dac_in);
    end
    total++; if (got.size() != 12) begin bad++; $display("FAIL %s ramp_ticks: got %0d want 12", tag, got.size()); end
    foreach (got[i]) begin
      total++; if (got[i] != want[i]) begin bad++; $display("FAIL %s ramp[%0d]: got %0d want %0d", tag, i, got[i], want[i]); end
    end
  endtask

  task automatic test_underflow();
    int ucnt = 0, eucnt = 0;
    bit pu = 0, seen = 0;
    s_valid = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      total++; if (underflow !== e_uf) begin bad++; $display("FAIL uf: got %b want %b", underflow, e_uf); end
      total++; if (dac_in !== 16'(m_dac)) begin bad++; $display("FAIL uf_dac: got %0d want %0d", dac_in, m_dac); end
      if (e_uf) eucnt++;
      if (underflow === 1'b1) begin
        ucnt++;
        total++; if (pu) begin bad++; $display("FAIL uf_width: got 2+ cycles want 1"); end
      end
      pu = underflow;
    end
    total++; if (ucnt != eucnt || ucnt == 0) begin bad++; $display("FAIL uf_count: got %0d want %0d", ucnt, eucnt); end
    total++; if (dac_in !== 16'sd1200) begin bad++; $display("FAIL uf_settle: got %0d want 1200", dac_in); end
    s_valid = 1;
    s_data = 16'sd2000;
    cyc();
    s_data = 16'sd1000;
    cyc();
    s_valid = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      total++; if (dac_in !== 16'(m_dac)) begin bad++; $display("FAIL resume_dac: got %0d want %0d", dac_in, m_dac); end
      if (dac_in === 16'sd1400) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL resume_interp: got no 1400 want 1400"); end
  endtask

  task automatic test_swing();
    int vals[4] = '{32767, -32768, 0, 0};
    int want[4] = '{32767, 16383, -1, -16385};
    int got[$];
    bit was_ce, was_run;
    en = 0; s_valid = 0;
    cyc();
    total++; if (dac_in !== 16'sd0) begin bad++; $display("FAIL flush_dac: got %0d want 0", dac_in); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL flush_level: got %0d want 0", level); end
    en = 1;
    foreach (vals[k]) begin
      s_valid = 1;
      s_data = 16'(vals[k]);
      cyc();
    end
    s_valid = 0;
    for (int i = 0; i < 200 && got.size() < 8; i++) begin
      was_ce = e_ce;
      was_run = m_run;
      cyc();
      total++; if (dac_in !== 16'(m_dac)) begin bad++; $display("FAIL swing_dac: got %0d want %0d", dac_in, m_dac); end
      if (was_ce && was_run) got.push_back(dac_in);
    end
    total++; if (got.size() != 8) begin bad++; $display("FAIL swing_ticks: got %0d want 8", got.size()); end
    for (int i = 4; i < got.size(); i++) begin
      total++; if (got[i] != want[i-4]) begin bad++; $display("FAIL swing[%0d]: got %0d want %0d", i - 4, got[i], want[i-4]); end
    end
  endtask

  task automatic test_backpressure();
    bit acc, saw87 = 0;
    logic [3:0] plv = '0;
    en = 0; s_valid = 0;
    cyc();
    en = 1;
    s_valid = 1;
    s_data = 16'($urandom);
    for (int i = 0; i < 160; i++) begin
      acc = e_rdy;
      cyc();
      total++; if (s_ready !== e_rdy) begin bad++; $display("FAIL bp_ready: got %b want %b", s_ready, e_rdy); end
      total++; if (level !== 4'(e_lvl)) begin bad++; $display("FAIL bp_level: got %0d want %0d", level, e_lvl); end
      total++; if (dac_in !== 16'(m_dac)) begin bad++; $display("FAIL bp_dac: got %0d want %0d", dac_in, m_dac); end
      if (e_lvl == D) begin
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", s_ready); end
      end
      if (plv == 4'd8 && level == 4'd7) saw87 = 1;
      plv = level;
      if (acc) s_data = 16'($urandom);
    end
    s_valid = 0;
    total++; if (!saw87) begin bad++; $display("FAIL bp_8to7: got none want level 8 then 7"); end
  endtask

  task automatic test_abort();
    int k;
    for (k = 0; k < 100 && !(m_run && m_n % R == 2); k++) cyc();
    total++; if (k == 100) begin bad++; $display("FAIL abort_wait_en: got timeout want phase 2"); end
    en = 0;
    cyc();
    total++; if (dac_in !== 16'sd0) begin bad++; $display("FAIL abort_en_dac: got %0d want 0", dac_in); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL abort_en_level: got %0d want 0", level); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_en_ready: got %b want 0", s_ready); end
    test_ramp("after_en");
    for (k = 0; k < 100 && !(m_run && m_n % R == 2); k++) cyc();
    total++; if (k == 100) begin bad++; $display("FAIL abort_wait_rst: got timeout want phase 2"); end
    #2 rst = 1;
    #1;
    total++; if (dac_in !== 16'sd0) begin bad++; $display("FAIL abort_rst_dac: got %0d want 0", dac_in); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL abort_rst_level: got %0d want 0", level); end
    total++; if (clk_en !== 1'b0) begin bad++; $display("FAIL abort_rst_clk_en: got %b want 0", clk_en); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_rst_ready: got %b want 0", s_ready); end
    model_clear();
    upd_exp();
    cyc();
    rst = 0;
    upd_exp();
    test_ramp("after_rst");
  endtask

  initial begin
    model_clear();
    upd_exp();
    test_reset();
    test_ramp("first");
    test_underflow();
    test_swing();
    test_backpressure();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
